// File: rtl/enc_acq_ctrl.sv
// Acquisition sequencer for the dual-channel encoder counters: arms on START, waits for the
// selected index edge, snapshots both counts every DIV clocks into a small FIFO stream.
module enc_acq_ctrl #(
    parameter int CNT_W = 64,
    parameter int DIV_W = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             zsel,
    input  logic [15:0]      nsamp,
    input  logic [DIV_W-1:0] div,
    input  logic             z0,
    input  logic             z1,
    input  logic [CNT_W-1:0] cnt_a0,
    input  logic [CNT_W-1:0] cnt_a1,
    output logic             arm,
    output logic             sel,
    output logic             valid,
    input  logic             ready,
    output logic [CNT_W-1:0] data0,
    output logic [CNT_W-1:0] data1,
    output logic [15:0]      seq,
    output logic             busy,
    output logic             done,
    output logic             ovf
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WAITZ, S_RUN, S_DRAIN, S_FIN} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] d0;
        logic [CNT_W-1:0] d1;
        logic [15:0]      sq;
    } snap_t;

    state_t           state;
    snap_t            mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_nxt;
    logic [DIV_W-1:0] div_m1, div_cnt;
    logic [15:0]      nsamp_q, samp_cnt, seq_cnt;
    logic             z_prev, z_cur, tick, pop, full, push, drop, last;

    assign z_cur = sel ? z1 : z0;
    // STOP beats a tick landing in the same cycle
    assign tick  = (state == S_RUN) && !stop && (div_cnt == '0);
    assign pop   = valid && ready;
    assign full  = (count == (AW+1)'(DEPTH));
    assign push  = tick && (!full || pop);
    assign drop  = tick && full && !pop;
    assign last  = tick && (nsamp_q != 16'd0) && (samp_cnt == nsamp_q - 16'd1);

    assign data0 = mem[rd_ptr].d0;
    assign data1 = mem[rd_ptr].d1;
    assign seq   = mem[rd_ptr].sq;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + (AW+1)'(1);
        else if (!push && pop)
            count_nxt = count - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{d0: cnt_a0, d1: cnt_a1, sq: seq_cnt};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            valid <= (count_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            arm      <= 1'b0;
            sel      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            z_prev   <= 1'b0;
            nsamp_q  <= '0;
            div_m1   <= '0;
            div_cnt  <= '0;
            samp_cnt <= '0;
            seq_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state    <= S_WAITZ;
                    busy     <= 1'b1;
                    arm      <= 1'b1;
                    sel      <= zsel;
                    nsamp_q  <= nsamp;
                    div_m1   <= (div == '0) ? '0 : div - DIV_W'(1);
                    // a Z already high at START must not count as an edge
                    z_prev   <= zsel ? z1 : z0;
                    ovf      <= 1'b0;
                    samp_cnt <= '0;
                    seq_cnt  <= '0;
                end
                S_WAITZ: begin
                    z_prev <= z_cur;
                    if (stop) begin
                        state <= S_DRAIN;
                        arm   <= 1'b0;
                    end else if (z_cur && !z_prev) begin
                        state   <= S_RUN;
                        div_cnt <= div_m1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state <= S_DRAIN;
                        arm   <= 1'b0;
                    end else if (tick) begin
                        div_cnt  <= div_m1;
                        seq_cnt  <= seq_cnt + 16'd1;
                        samp_cnt <= samp_cnt + 16'd1;
                        if (drop)
                            ovf <= 1'b1;
                        if (last) begin
                            state <= S_DRAIN;
                            arm   <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                S_DRAIN: if (count == '0) begin
                    state <= S_FIN;
                    done  <= 1'b1;
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
